result_writeback_arbiter: RTL and testbench
===========================================

# result_writeback_arbiter

Collects results from the three execution units (ADD, MULT, MULADD) and merges them onto one registered writeback channel toward the register file. It is the return path for operands steered out to the units by source select code: ADD = 2'b00, MULT = 2'b01, MULADD = 2'b10. Each unit gets a one-entry holding slot with a valid/ready handshake, and an arbiter grants one held result per cycle into the output register.

## Interface
Parameters:
- DATA_W, 32, result width
- TAG_W, 5, destination register tag width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- add_valid  in  1  ADD result offered
- add_result  in  DATA_W  ADD result value
- add_tag  in  TAG_W  ADD destination tag
- add_ready  out  1  ADD slot empty, can accept
- mult_valid / mult_result / mult_tag / mult_ready  same as ADD, for MULT
- muladd_valid / muladd_result / muladd_tag / muladd_ready  same as ADD, for MULADD
- wb_valid  out  1  writeback entry present
- wb_data  out  DATA_W  writeback value
- wb_tag  out  TAG_W  writeback destination tag
- wb_src  out  2  originating unit: 00 ADD, 01 MULT, 10 MULADD; 11 is never driven
- wb_ready  in  1  register file accepts the entry

## Operation
- Per-unit slot: `held_x`, `data_x`, `tag_x`. `x_ready = ~held_x`, driven combinationally from the slot only, with no path from wb_ready.
- Capture: on an edge where `x_valid & x_ready`, load the data and tag into the slot and set `held_x`.
- Output register is free when `~wb_valid | wb_ready`.
- When the output register is free and at least one slot is held, the arbiter picks one held slot. That slot's data, tag and source code move into the output register, and `held_x` clears on the same edge. At most one grant per cycle.
- When the output register is free and no slot is held, `wb_valid` goes to 0 on the next edge.
- When `wb_valid & ~wb_ready`: wb_data, wb_tag and wb_src hold stable, and no grant occurs.
- Units must hold valid, result and tag stable until ready is seen high. The block does not check this.
- A slot is never both captured and granted in the same cycle, because capture requires the slot to be empty.
- Reset (asynchronous, any time, including mid-transfer):
  - all slots clear; held entries are discarded
  - wb_valid, wb_data, wb_tag and wb_src go to 0
  - the round-robin pointer goes to MULADD
  - all x_ready read 1 while in reset and after release

## Timing
- Latency: valid accepted at edge N gives wb_valid=1 after edge N+1, if the output register is free and the slot wins arbitration.
- Per-unit throughput: one result per 2 cycles. The slot frees at the grant edge, so ready is high the following cycle.
- Aggregate throughput: 1 result/cycle when two or more units are streaming.
- Back-pressure: each cycle wb_ready is low while wb_valid is high adds one cycle to every pending slot.
- Simultaneous capture on all three units in one cycle: the three entries drain on three consecutive edges, in arbitration order.

## Configuration
- `RESULT_WB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - Search order starts at the unit after the last granted one (ADD→MULT→MULADD→ADD).
  - The pointer updates only on a grant.
  - The reset pointer is MULADD, so ADD wins first.
  - Starvation-free: a held slot waits at most 2 grants.
- `RESULT_WB_ROUND_ROBIN_EN` undefined: fixed priority ADD > MULT > MULADD, with no pointer state. MULADD can starve under continuous ADD/MULT traffic.

## Test plan
- Reset then single ADD: add_valid=1, result 0x0000_1234, tag 3 at edge N → add_ready=0 at N+1; wb_valid=1, wb_data=0x1234, wb_tag=3, wb_src=00 after N+1; add_ready=1 after N+1.
- All three valid in the same cycle (0xA, 0xB, 0xC; wb_ready=1):
  - round-robin build: wb_src sequence 00, 01, 10 on consecutive cycles
  - a second burst afterwards starts with 00 again (pointer at MULADD)
- Back-pressure: MULT result 0xDEAD_BEEF with wb_ready=0 for 4 cycles → wb_valid, wb_data and wb_src=01 stable all 4 cycles; mult_ready stays 1 after the grant; a second MULT result is held until wb_ready=1.
- Starvation check with ADD and MULT streaming continuously:
  - round-robin build: a MULADD result 0x77 appears on wb within 3 cycles of being held
  - fixed-priority build: 0x77 does not appear until ADD/MULT traffic stops
- Mid-operation reset: all three slots held and wb_valid=1, then rst_n low asynchronously between edges → wb_valid, wb_data, wb_tag and wb_src read 0 immediately, all readies read 1, and no stale result appears after release.

Source files
------------

// File: rtl/result_writeback_arbiter.sv
// Merges ADD/MULT/MULADD results into one registered writeback channel.
// Define RESULT_WB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module result_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add_valid,
  input  logic [DATA_W-1:0] add_result,
  input  logic [TAG_W-1:0]  add_tag,
  output logic              add_ready,
  input  logic              mult_valid,
  input  logic [DATA_W-1:0] mult_result,
  input  logic [TAG_W-1:0]  mult_tag,
  output logic              mult_ready,
  input  logic              muladd_valid,
  input  logic [DATA_W-1:0] muladd_result,
  input  logic [TAG_W-1:0]  muladd_tag,
  output logic              muladd_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [1:0]        wb_src,
  input  logic              wb_ready
);

  typedef enum logic [1:0] {
    SRC_ADD    = 2'b00,
    SRC_MULT   = 2'b01,
    SRC_MULADD = 2'b10
  } src_e;

  logic [2:0]        held;
  logic [DATA_W-1:0] slot_data [3];
  logic [TAG_W-1:0]  slot_tag  [3];
  logic [2:0]        in_valid;
  logic [DATA_W-1:0] in_data   [3];
  logic [TAG_W-1:0]  in_tag    [3];
  logic              out_free;
  logic              grant;
  logic [2:0]        grant_vec;
  src_e              sel;
  src_e              wb_src_q;

  assign in_valid   = {muladd_valid, mult_valid, add_valid};
  assign in_data[0] = add_result;
  assign in_data[1] = mult_result;
  assign in_data[2] = muladd_result;
  assign in_tag[0]  = add_tag;
  assign in_tag[1]  = mult_tag;
  assign in_tag[2]  = muladd_tag;

  // Ready depends on slot occupancy alone, so no combinational path from wb_ready.
  assign add_ready    = ~held[0];
  assign mult_ready   = ~held[1];
  assign muladd_ready = ~held[2];

  assign out_free  = ~wb_valid | wb_ready;
  assign grant     = out_free & (|held);
  assign grant_vec = grant ? (3'b001 << sel) : 3'b000;

`ifdef RESULT_WB_ROUND_ROBIN_EN
  src_e last_grant;

  always_comb begin
    sel = SRC_ADD;
    case (last_grant)
      SRC_ADD:  sel = held[1] ? SRC_MULT : (held[2] ? SRC_MULADD : SRC_ADD);
      SRC_MULT: sel = held[2] ? SRC_MULADD : (held[0] ? SRC_ADD : SRC_MULT);
      default:  sel = held[0] ? SRC_ADD : (held[1] ? SRC_MULT : SRC_MULADD);
    endcase
  end

  // Pointer starts at MULADD so the first search begins with ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_MULADD;
    end else if (grant) begin
      last_grant <= sel;
    end
  end
`else
  always_comb begin
    sel = SRC_MULADD;
    if (held[0]) begin
      sel = SRC_ADD;
    end else if (held[1]) begin
      sel = SRC_MULT;
    end
  end
`endif

  // Capture needs an empty slot and grant needs a full one, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        slot_data[i] <= '0;
        slot_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && !held[i]) begin
          held[i]      <= 1'b1;
          slot_data[i] <= in_data[i];
          slot_tag[i]  <= in_tag[i];
        end else if (grant_vec[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
      wb_src_q <= SRC_ADD;
    end else if (out_free) begin
      wb_valid <= |held;
      if (|held) begin
        wb_data  <= slot_data[sel];
        wb_tag   <= slot_tag[sel];
        wb_src_q <= sel;
      end
    end
  end

  assign wb_src = wb_src_q;

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Directed self-checking bench for result_writeback_arbiter.
// Round-robin expectations apply when RESULT_WB_ROUND_ROBIN_EN is defined.
module tb_result_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        add_valid, mult_valid, muladd_valid;
  logic [31:0] add_result, mult_result, muladd_result;
  logic [4:0]  add_tag, mult_tag, muladd_tag;
  logic        add_ready, mult_ready, muladd_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_tag;
  logic [1:0]  wb_src;
  logic        wb_ready;

  int checks = 0;
  int errors = 0;

  result_writeback_arbiter #(.DATA_W(32), .TAG_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .add_valid     (add_valid),
    .add_result    (add_result),
    .add_tag       (add_tag),
    .add_ready     (add_ready),
    .mult_valid    (mult_valid),
    .mult_result   (mult_result),
    .mult_tag      (mult_tag),
    .mult_ready    (mult_ready),
    .muladd_valid  (muladd_valid),
    .muladd_result (muladd_result),
    .muladd_tag    (muladd_tag),
    .muladd_ready  (muladd_ready),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_tag        (wb_tag),
    .wb_src        (wb_src),
    .wb_ready      (wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic av, input logic mv, input logic xv,
                                input logic [31:0] ad, input logic [31:0] md, input logic [31:0] xd);
    add_valid     = av;
    mult_valid    = mv;
    muladd_valid  = xv;
    add_result    = ad;
    mult_result   = md;
    muladd_result = xd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  logic [31:0] burst_data [3];
  logic        seen;

  initial begin
    burst_data[0] = 32'hA;
    burst_data[1] = 32'hB;
    burst_data[2] = 32'hC;
    rst_n    = 1'b0;
    wb_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    add_tag = 5'd0; mult_tag = 5'd0; muladd_tag = 5'd0;

    #2;
    check_output("rst_wb_valid", wb_valid, 0);
    check_output("rst_add_ready", add_ready, 1);
    check_output("rst_mult_ready", mult_ready, 1);
    check_output("rst_muladd_ready", muladd_ready, 1);
    #5;
    rst_n = 1'b1;

    $display("[TB] single ADD");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0);
    add_tag = 5'd3;
    tick();
    check_output("single_add_ready_low", add_ready, 0);
    check_output("single_wb_not_yet", wb_valid, 0);
    add_valid = 1'b0;
    tick();
    check_output("single_wb_valid", wb_valid, 1);
    check_output("single_wb_data", wb_data, 32'h1234);
    check_output("single_wb_tag", wb_tag, 3);
    check_output("single_wb_src", wb_src, 0);
    check_output("single_add_ready_back", add_ready, 1);
    tick();
    check_output("single_wb_idle", wb_valid, 0);

    $display("[TB] simultaneous bursts");
    do_reset();
    for (int b = 0; b < 2; b++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, burst_data[0], burst_data[1], burst_data[2]);
      add_tag = 5'd1; mult_tag = 5'd2; muladd_tag = 5'd3;
      tick();
      check_output("burst_readies_low", {add_ready, mult_ready, muladd_ready}, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        tick();
        check_output("burst_wb_valid", wb_valid, 1);
        check_output("burst_wb_src", wb_src, i);
        check_output("burst_wb_data", wb_data, burst_data[i]);
        check_output("burst_wb_tag", wb_tag, i + 1);
      end
      tick();
      check_output("burst_drained", wb_valid, 0);
    end

    $display("[TB] back-pressure");
    wb_ready = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    mult_tag = 5'd7;
    tick();
    check_output("bp_mult_ready_low", mult_ready, 0);
    mult_valid = 1'b0;
    tick();
    check_output("bp_wb_valid", wb_valid, 1);
    check_output("bp_wb_data", wb_data, 32'hDEAD_BEEF);
    check_output("bp_mult_ready_after_grant", mult_ready, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h5555, 32'h0);
    mult_tag = 5'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      mult_valid = 1'b0;
      check_output("bp_stall_valid", wb_valid, 1);
      check_output("bp_stall_data", wb_data, 32'hDEAD_BEEF);
      check_output("bp_stall_tag", wb_tag, 7);
      check_output("bp_stall_src", wb_src, 1);
      check_output("bp_second_held", mult_ready, 0);
    end
    wb_ready = 1'b1;
    tick();
    check_output("bp_second_data", wb_data, 32'h5555);
    check_output("bp_second_tag", wb_tag, 8);
    check_output("bp_second_src", wb_src, 1);
    check_output("bp_mult_ready_free", mult_ready, 1);
    tick();
    check_output("bp_drained", wb_valid, 0);

    $display("[TB] starvation");
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h11, 32'h22, 32'h0);
    add_tag = 5'd1; mult_tag = 5'd2;
    tick(); tick(); tick();
    muladd_valid  = 1'b1;
    muladd_result = 32'h77;
    muladd_tag    = 5'd9;
    tick();
    check_output("starve_muladd_captured", muladd_ready, 0);
    muladd_valid = 1'b0;
    seen = 1'b0;
`ifdef RESULT_WB_ROUND_ROBIN_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_valid && wb_src == 2'b10 && wb_data == 32'h77) seen = 1'b1;
    end
    check_output("rr_muladd_within_3", seen, 1);
    add_valid = 1'b0; mult_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_valid && wb_src == 2'b10) seen = 1'b1;
    end
    check_output("fixed_muladd_starved", seen, 0);
    check_output("fixed_muladd_still_held", muladd_ready, 0);
    add_valid = 1'b0; mult_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wb_valid && wb_src == 2'b10 && wb_data == 32'h77 && wb_tag == 5'd9) seen = 1'b1;
    end
    check_output("fixed_muladd_after_stop", seen, 1);
`endif
    check_output("starve_drained", wb_valid, 0);

    $display("[TB] mid-operation reset");
    wb_ready = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3);
    add_tag = 5'd4; mult_tag = 5'd5; muladd_tag = 5'd6;
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check_output("mr_wb_valid_pre", wb_valid, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0);
    tick();
    add_valid = 1'b0;
    check_output("mr_all_held", {add_ready, mult_ready, muladd_ready}, 0);
    check_output("mr_wb_data_pre", wb_data, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("mr_wb_valid", wb_valid, 0);
    check_output("mr_wb_data", wb_data, 0);
    check_output("mr_wb_tag", wb_tag, 0);
    check_output("mr_wb_src", wb_src, 0);
    check_output("mr_readies", {add_ready, mult_ready, muladd_ready}, 3'b111);
    #2;
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("mr_no_stale", wb_valid, 0);
    end
    check_output("mr_readies_after", {add_ready, mult_ready, muladd_ready}, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
